// File: rtl/alu_1to2_router.sv
// Routes one result stream to two consumers through independent 2-entry FIFOs.
// Per-destination counters record accepted words and wrap silently.
module alu_1to2_router #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic [DATA_W-1:0] mem_q  [2][2];
    logic [DATA_W-1:0] mem_d  [2][2];
    logic [1:0]        occ_q  [2];
    logic [1:0]        occ_d  [2];
    logic [DATA_W-1:0] dout_q [2];
    logic [DATA_W-1:0] dout_d [2];
    logic [CNT_W-1:0]  cnt_q  [2];
    logic [CNT_W-1:0]  cnt_d  [2];
    logic [1:0]        rd_q, rd_d;
    logic [1:0]        wr_q, wr_d;
    logic [1:0]        full;
    logic [1:0]        push;
    logic [1:0]        pop;

    assign full[0] = (occ_q[0] == 2'd2);
    assign full[1] = (occ_q[1] == 2'd2);

    // A pop from a full FIFO does not raise in_ready in the same cycle.
    assign in_ready = !full[in_sel] && !rst;

    assign push[0] = in_valid && in_ready && !in_sel;
    assign push[1] = in_valid && in_ready &&  in_sel;

    assign out0_valid = (occ_q[0] != 2'd0);
    assign out1_valid = (occ_q[1] != 2'd0);
    assign pop[0]     = out0_valid && out0_ready;
    assign pop[1]     = out1_valid && out1_ready;

    assign out0_data = dout_q[0];
    assign out1_data = dout_q[1];
    assign cnt0      = cnt_q[0];
    assign cnt1      = cnt_q[1];

    always_comb begin
        rd_d = rd_q;
        wr_d = wr_q;
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < 2; e++) begin
                mem_d[k][e] = mem_q[k][e];
            end
            occ_d[k] = occ_q[k];
            cnt_d[k] = cnt_q[k];
            if (push[k]) begin
                mem_d[k][wr_q[k]] = in_data;
                wr_d[k]           = ~wr_q[k];
                cnt_d[k]          = cnt_q[k] + CNT_W'(1);
            end
            if (pop[k]) begin
                rd_d[k] = ~rd_q[k];
            end
            case ({push[k], pop[k]})
                2'b10:   occ_d[k] = occ_q[k] + 2'd1;
                2'b01:   occ_d[k] = occ_q[k] - 2'd1;
                default: occ_d[k] = occ_q[k];
            endcase
            // Output register tracks the next head; an empty FIFO keeps its last word.
            dout_d[k] = (occ_d[k] != 2'd0) ? mem_d[k][rd_d[k]] : dout_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
            wr_q <= '0;
            for (int k = 0; k < 2; k++) begin
                for (int e = 0; e < 2; e++) begin
                    mem_q[k][e] <= '0;
                end
                occ_q[k]  <= '0;
                dout_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            for (int k = 0; k < 2; k++) begin
                for (int e = 0; e < 2; e++) begin
                    mem_q[k][e] <= mem_d[k][e];
                end
                occ_q[k]  <= occ_d[k];
                dout_q[k] <= dout_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

endmodule

// File: doc/alu_1to2_router.md
Name: alu_1to2_router

Overview:
- Steers one stream of datapath results to one of two consumers; the inverse of the ALU operand 2:1 select.
- The producer presents data plus a 1-bit destination select. The block buffers each destination independently in a 2-entry FIFO with a valid/ready handshake on every side.
- It sits between the ALU result stage and the two downstream sinks: writeback (dest 0) and branch/address unit (dest 1).
- Per-destination transfer counters support debug and verification.

Parameters:
- DATA_W, 6, payload width (6 in the current reduced datapath, 32 in the final core)
- CNT_W, 8, width of each per-destination accepted-transfer counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_sel  input  1  destination: 0 selects out0, 1 selects out1
- in_data  input  DATA_W  payload
- out0_valid  output  1  head of FIFO 0 valid
- out0_ready  input  1  consumer 0 takes the head
- out0_data  output  DATA_W  head of FIFO 0
- out1_valid  output  1  head of FIFO 1 valid
- out1_ready  input  1  consumer 1 takes the head
- out1_data  output  DATA_W  head of FIFO 1
- cnt0  output  CNT_W  words accepted for dest 0
- cnt1  output  CNT_W  words accepted for dest 1

Behaviour:
- Clock and reset: one clock domain. rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: both FIFOs empty; out0_valid=out1_valid=0; out0_data=out1_data=0; cnt0=cnt1=0.
- Reset mid-operation: rst discards all buffered words the same edge, with no drain. in_ready is forced 0 while rst is high.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer k occurs when outk_valid && outk_ready at a rising edge.
- in_ready (combinational):
  - in_ready = !full[in_sel] && !rst.
  - It depends on in_sel and on nothing else on the input side. It does not depend on in_valid.
  - A pop from the full FIFO in the same cycle does NOT raise in_ready (no fall-through when full).
- FIFO storage: each FIFO is 2 entries with a 2-bit occupancy count (0..2) and 1-bit read/write pointers that wrap 1->0.
- Routing: an accepted word is written only into FIFO[in_sel]. The other FIFO is untouched.
- Latency: a word accepted at edge N is visible on outk_valid/outk_data after edge N, i.e. in cycle N+1. There is no combinational in->out path.
- Ordering: per-destination order is preserved. There is no ordering relation between destinations.
- Output stability: outk_data holds the FIFO head and stays stable while outk_valid && !outk_ready.
- Empty FIFO: outk_valid=0 and outk_data holds its last value (0 after reset); consumers must ignore it.
- Occupancy updates per FIFO per edge:
  - push only: +1
  - pop only: -1
  - push and pop together (only possible at occupancy 1): occupancy stays 1, head advances, new word becomes tail.
  - push and pop together at occupancy 0 cannot occur, since valid is 0.
- Full FIFO with in_sel selecting it and in_valid=1: in_ready=0, the producer stalls, and the other FIFO continues draining independently.
- Counters:
  - cntk increments by 1 on each input transfer to dest k.
  - Wraps modulo 2^CNT_W (255 -> 0) with no saturation and no flag.
  - Pops do not affect the counters.
- in_sel and in_data are don't-care when in_valid=0, but in_ready still reflects in_sel.

Test Plan:
- Reset then idle: hold rst 2 cycles -> all valids 0, data 0, cnt0=cnt1=0, in_ready=0 during rst and 1 afterwards.
- Single routing: send 0x15 with sel=0, then 0x2A with sel=1, consumers ready -> out0 shows 0x15 one cycle after accept, out1 shows 0x2A one cycle after its accept; cnt0=1, cnt1=1.
- Backpressure/full: out0_ready=0, send 0x01, 0x02, 0x03 to dest 0 -> first two accepted; in_ready=0 for the third, which the producer holds. Then assert out0_ready -> outputs 0x01, 0x02, 0x03 in order; 0x03 is accepted only the cycle after the first pop.
- Independence: FIFO 0 full and stalled, in_sel=1 with data 0x3F -> in_ready=1 and 0x3F appears on out1 next cycle; FIFO 0 contents unchanged.
- Simultaneous push/pop at occupancy 1: FIFO 1 holds 0x07, out1_ready=1, push 0x08 to dest 1 same edge -> next cycle out1_data=0x08, out1_valid=1, occupancy 1.
- Reset mid-stream and counter wrap:
  - Pulse rst with both FIFOs holding 2 words -> both valids 0 next cycle, counters 0.
  - Then 256 accepts to dest 0 -> cnt0 returns to 0.
